// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard control for a 5-stage pipeline.
// Tracks the instructions in EXE and MEM as two shadow slots. It raises a
// combinational STALL on RAW hazards that forwarding cannot cover. It also
// registers the EXE operand-mux selects one clock ahead of their use.
//
// Handshake: ID_VALID_IN works as "valid" and ~STALL works as "ready".
// An ID instruction issues into EXE on a clock edge only when
// ID_VALID_IN=1, STALL=0 and FLUSH_IN=0. FLUSH_IN kills the ID instruction
// outright and never causes a stall.
module forward_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       FWD_EN_IN,
    input  logic       FLUSH_IN,
    input  logic       ID_VALID_IN,
    input  logic [3:0] ID_SRC1_IN,
    input  logic [3:0] ID_SRC2_IN,
    input  logic       ID_SRC1_V_IN,
    input  logic       ID_SRC2_V_IN,
    input  logic [3:0] ID_DEST_IN,
    input  logic       ID_WB_EN_IN,
    input  logic       ID_MEM_R_EN_IN,
    output logic       STALL,
    output logic [1:0] sel_src1,
    output logic [1:0] sel_src2,
    output logic [15:0] HAZARD_CNT,
    output logic       fsm_state
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    state_t      state_q;

    logic        ex_v, ex_wb, ex_memr;
    logic [3:0]  ex_dest;
    logic        mem_v, mem_wb;
    logic [3:0]  mem_dest;

    logic        ex_m1, ex_m2, mem_m1, mem_m2;
    logic        stall_cond;
    logic        issue;
    logic [1:0]  sel1_d, sel2_d;

    // Slot/source match detection, hazard decision and next-select computation
    always_comb begin
        ex_m1  = ex_v  && ex_wb  && ID_SRC1_V_IN && (ex_dest  == ID_SRC1_IN);
        ex_m2  = ex_v  && ex_wb  && ID_SRC2_V_IN && (ex_dest  == ID_SRC2_IN);
        mem_m1 = mem_v && mem_wb && ID_SRC1_V_IN && (mem_dest == ID_SRC1_IN);
        mem_m2 = mem_v && mem_wb && ID_SRC2_V_IN && (mem_dest == ID_SRC2_IN);

        // Forwarding covers everything except a load still in EXE.
        if (FWD_EN_IN)
            stall_cond = ex_memr && (ex_m1 || ex_m2);
        else
            stall_cond = ex_m1 || ex_m2 || mem_m1 || mem_m2;

        STALL = ID_VALID_IN && !FLUSH_IN && stall_cond;
        issue = ID_VALID_IN && !FLUSH_IN && !STALL;

        sel1_d = SEL_REG;
        sel2_d = SEL_REG;
        if (issue && FWD_EN_IN) begin
            // The younger producer (EXE) wins over the older one (MEM).
            if (ex_m1)       sel1_d = SEL_MEM;
            else if (mem_m1) sel1_d = SEL_WB;
            if (ex_m2)       sel2_d = SEL_MEM;
            else if (mem_m2) sel2_d = SEL_WB;
        end
    end

    // Shadow slots, registered selects, stall counter and RUN/HOLD state
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_v       <= 1'b0;
            ex_wb      <= 1'b0;
            ex_memr    <= 1'b0;
            ex_dest    <= 4'd0;
            mem_v      <= 1'b0;
            mem_wb     <= 1'b0;
            mem_dest   <= 4'd0;
            sel_src1   <= SEL_REG;
            sel_src2   <= SEL_REG;
            HAZARD_CNT <= 16'd0;
            state_q    <= RUN;
        end else begin
            mem_v    <= ex_v;
            mem_wb   <= ex_wb;
            mem_dest <= ex_dest;
            if (issue) begin
                ex_v    <= 1'b1;
                ex_wb   <= ID_WB_EN_IN;
                ex_memr <= ID_MEM_R_EN_IN;
                ex_dest <= ID_DEST_IN;
            end else begin
                ex_v    <= 1'b0;
                ex_wb   <= 1'b0;
                ex_memr <= 1'b0;
            end
            sel_src1 <= sel1_d;
            sel_src2 <= sel2_d;
            if (STALL && (HAZARD_CNT != 16'hFFFF))
                HAZARD_CNT <= HAZARD_CNT + 16'd1;
            state_q <= STALL ? HOLD : RUN;
        end
    end

    assign fsm_state = state_q;

endmodule
